// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller driving a req/ack data bus,
// stalling the pipeline and returning aligned, extended load data.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        mem_stall_o,
  output logic        mem_flush_o,
  output logic        access_err_o,
  output logic [31:0] load_data_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d, uns_q, uns_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  lo_q, lo_d, size_q, size_d;
  logic        access, illegal;
  logic [3:0]  be_n;
  logic [31:0] wd_n, lane, ext;
  assign access  = mem_read_i | mem_write_i;
  assign illegal = (mem_read_i & mem_write_i) | (mem_size_i == 2'b11) |
                   ((mem_size_i == 2'b01) & addr_i[0]) |
                   ((mem_size_i == 2'b10) & (|addr_i[1:0]));
  assign be_n = mem_size_i == 2'b00 ? 4'b0001 << addr_i[1:0] :
                mem_size_i == 2'b01 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd_n = mem_size_i == 2'b00 ? {4{wdata_i[7:0]}} :
                mem_size_i == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
  assign lane = bus_rdata_i >> {lo_q, 3'b000};
  assign ext  = size_q == 2'b00 ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
                size_q == 2'b01 ? {{16{~uns_q & lane[15]}}, lane[15:0]} : lane;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    lo_d        = lo_q;
    size_d      = size_q;
    ld_d        = ld_q;
    mem_stall_o = 1'b0;
    case (state_q)
      IDLE: if (access) begin
        if (illegal) begin
          state_d = ERR;
          ld_d    = '0;
        end else begin
          state_d     = BUSY;
          mem_stall_o = 1'b1;
          cnt_d       = '0;
          we_d        = mem_write_i;
          uns_d       = mem_unsigned_i;
          addr_d      = {addr_i[31:2], 2'b00};
          wdata_d     = wd_n;
          be_d        = be_n;
          lo_d        = addr_i[1:0];
          size_d      = mem_size_i;
        end
      end
      BUSY: begin
        mem_stall_o = 1'b1;
        cnt_d       = cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
        if (bus_ack_i) begin
          state_d = DONE;
          ld_d    = we_q ? '0 : ext;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = ERR;
          ld_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      ld_q    <= ld_d;
    end
  end
  assign bus_req_o    = state_q == BUSY;
  assign bus_we_o     = we_q;
  assign bus_addr_o   = addr_q;
  assign bus_be_o     = be_q;
  assign bus_wdata_o  = wdata_q;
  assign load_data_o  = ld_q;
  assign mem_flush_o  = state_q == ERR;
  assign access_err_o = state_q == ERR;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store transactions checked
// against an arithmetic reference model of the memory access rules.
module tb_mem_access_unit;
  localparam int TO = 8;
  logic        clk = 0, rst = 1;
  logic        mem_read_i = 0, mem_write_i = 0, mem_unsigned_i = 0;
  logic [1:0]  mem_size_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0, bus_rdata_i = 0;
  logic        bus_ack_i = 0;
  logic        bus_req_o, bus_we_o, mem_stall_o, mem_flush_o, access_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, load_data_o;
  logic [3:0]  bus_be_o;
  int errors = 0, checks = 0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .mem_stall_o(mem_stall_o),
    .mem_flush_o(mem_flush_o), .access_err_o(access_err_o), .load_data_o(load_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_load(input int sz, input logic un, input int a, input logic [31:0] r);
    logic [31:0] v;
    v = r >> (8 * a);
    if (sz == 0) begin
      v = v % 256;
      if (!un && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = v % 65536;
      if (!un && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  // d = BUSY-cycle index (0-based) carrying the ack; d >= TO means no ack
  task automatic access(input string tag, input logic rd, input logic wr, input int sz,
                        input logic un, input logic [31:0] a, input logic [31:0] wd,
                        input int d, input logic [31:0] rdat);
    int bytes, lo, stalls;
    logic legal, ok;
    logic [31:0] e_be, e_wd, e_ld;
    bytes = 1 << sz;
    lo    = int'(a % 4);
    legal = !(rd && wr) && sz != 3 && (a % bytes) == 0;
    e_be  = sz == 0 ? 32'(1 << lo) : sz == 1 ? 32'(3 << (lo & 2)) : 32'd15;
    e_wd  = sz == 0 ? (wd % 256) * 32'h01010101 : sz == 1 ? (wd % 65536) * 32'h00010001 : wd;
    e_ld  = m_load(sz, un, lo, rdat);
    ok    = legal && d < TO;
    mem_read_i = rd; mem_write_i = wr; mem_size_i = 2'(sz); mem_unsigned_i = un;
    addr_i = a; wdata_i = wd; bus_ack_i = 0;
    #2;
    chk({tag, " idle_stall"}, mem_stall_o, legal);
    chk({tag, " idle_req"}, bus_req_o, 0);
    stalls = legal ? 1 : 0;
    step();
    if (legal) begin
      for (int c = 0; c < TO; c++) begin
        bus_ack_i   = c == d;
        bus_rdata_i = c == d ? rdat : $urandom;
        #2;
        chk({tag, " busy_req"}, bus_req_o, 1);
        chk({tag, " busy_stall"}, mem_stall_o, 1);
        stalls++;
        if (c == 0) begin
          chk({tag, " addr"}, bus_addr_o, a & 32'hFFFFFFFC);
          chk({tag, " be"}, bus_be_o, e_be);
          chk({tag, " wdata"}, bus_wdata_o, e_wd);
          chk({tag, " we"}, bus_we_o, wr);
        end
        step();
        if (c == d) break;
      end
      bus_ack_i = 0;
      chk({tag, " stall_cycles"}, stalls, ok ? d + 2 : TO + 1);
    end
    #2;
    chk({tag, " end_stall"}, mem_stall_o, 0);
    chk({tag, " end_req"}, bus_req_o, 0);
    chk({tag, " end_err"}, access_err_o, !ok);
    chk({tag, " end_flush"}, mem_flush_o, !ok);
    chk({tag, " load_data"}, load_data_o, ok && !wr ? e_ld : 0);
    step();
    mem_read_i = 0; mem_write_i = 0;
    #2;
    chk({tag, " no_reissue"}, bus_req_o, 0);
    chk({tag, " after_stall"}, mem_stall_o, 0);
    step();
  endtask

  initial begin
    repeat (2) step();
    chk("rst_req", bus_req_o, 0);
    chk("rst_stall", mem_stall_o, 0);
    chk("rst_err", access_err_o, 0);
    chk("rst_ld", load_data_o, 0);
    chk("rst_be", bus_be_o, 0);
    rst = 0;
    step();
    bus_ack_i = 1;
    step();
    bus_ack_i = 0;
    #2;
    chk("stray_ack_req", bus_req_o, 0);
    chk("stray_ack_stall", mem_stall_o, 0);
    step();
    access("lw",       1, 0, 2, 0, 32'h100, 0, 2, 32'hDEADBEEF);
    access("lb",       1, 0, 0, 0, 32'h103, 0, 0, 32'h80123456);
    access("lbu",      1, 0, 0, 1, 32'h103, 0, 1, 32'h80123456);
    access("sh",       0, 1, 1, 0, 32'h22, 32'h0000ABCD, 0, 0);
    access("lw_mis",   1, 0, 2, 0, 32'h101, 0, 0, 0);
    access("lh_mis",   1, 0, 1, 0, 32'h103, 0, 0, 0);
    access("rsvd",     1, 0, 3, 0, 32'h100, 0, 0, 0);
    access("rdwr",     1, 1, 2, 0, 32'h100, 0, 0, 0);
    access("timeout",  1, 0, 2, 0, 32'h40, 0, TO, 32'h12345678);
    access("last_ack", 1, 0, 2, 0, 32'h40, 0, TO - 1, 32'h12345678);
    access("lh_neg",   1, 0, 1, 0, 32'h42, 0, 1, 32'h9ABC0000);
    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(1, 3));
      access("rand", op[0], op[1], int'($urandom_range(0, 3)), 1'($urandom),
             $urandom, $urandom, int'($urandom_range(0, TO + 1)), $urandom);
    end
    mem_read_i = 1; mem_size_i = 2'b10; addr_i = 32'h200;
    step();
    step();
    mem_read_i = 0;
    chk("rstbusy_req_pre", bus_req_o, 1);
    rst = 1;
    step();
    rst = 0;
    #2;
    chk("rstbusy_req", bus_req_o, 0);
    chk("rstbusy_stall", mem_stall_o, 0);
    chk("rstbusy_addr", bus_addr_o, 0);
    chk("rstbusy_be", bus_be_o, 0);
    chk("rstbusy_wd", bus_wdata_o, 0);
    chk("rstbusy_we", bus_we_o, 0);
    chk("rstbusy_ld", load_data_o, 0);
    bus_ack_i = 1; bus_rdata_i = 32'hFFFFFFFF;
    step();
    bus_ack_i = 0;
    #2;
    chk("late_ack_req", bus_req_o, 0);
    chk("late_ack_err", access_err_o, 0);
    chk("late_ack_ld", load_data_o, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
